// File: rtl/mio_arb_pkg.sv
// Shared types and constants for the MIO arbiter: FSM state encoding,
// grant encoding and the default memory read latency.
package mio_arb_pkg;

    localparam int MEM_LATENCY_DEF = 1;   // read data valid this many cycles after mem_en
    localparam int CNT_W           = 4;   // wide enough for latencies 1..15
    localparam int STATE_W         = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    typedef enum logic {
        GRANT_CPU = 1'b0,
        GRANT_DEV = 1'b1
    } grant_e;

endpackage

// File: rtl/mio_arb_if.sv
// Bus bundle between the two requesters (CPU and device), the shared memory
// and the arbiter. The arbiter uses the slave modport; the environment
// (requesters plus memory) uses the master modport.
interface mio_arb_if;
    import mio_arb_pkg::*;

    // CPU side
    logic               cpu_req;
    logic               cpu_we;
    logic [31:0]        cpu_addr;
    logic [31:0]        cpu_wdata;
    logic               MIO_ready;
    logic [31:0]        cpu_rdata;

    // Device (DMA/IO) side
    logic               dev_req;
    logic               dev_we;
    logic [31:0]        dev_addr;
    logic [31:0]        dev_wdata;
    logic               dev_ack;
    logic [31:0]        dev_rdata;

    // Memory side
    logic               mem_en;
    logic               mem_we;
    logic [31:0]        mem_addr;
    logic [31:0]        mem_wdata;
    logic [31:0]        mem_rdata;

    // Debug
    logic               grant;
    logic [STATE_W-1:0] state_out;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dev_req, dev_we, dev_addr, dev_wdata,
        input  mem_rdata,
        output MIO_ready, cpu_rdata, dev_ack, dev_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output grant, state_out
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dev_req, dev_we, dev_addr, dev_wdata,
        output mem_rdata,
        input  MIO_ready, cpu_rdata, dev_ack, dev_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  grant, state_out
    );

endinterface

// File: rtl/mio_arb_pick.sv
// Winner selection between the CPU and device requests. A lone request wins
// outright; a tie goes to whichever requester did not win last time. Tying
// last_winner to GRANT_DEV turns this into fixed CPU priority.
module mio_arb_pick
    import mio_arb_pkg::*;
(
    input  logic   cpu_req,
    input  logic   dev_req,
    input  grant_e last_winner,
    output grant_e winner,
    output logic   valid
);

    // NOTE: every output gets a default before the branches, so no path leaves it unassigned and no latch is inferred.
    // Resolve the winner from the two requests and the tie-break history.
    always_comb begin
        valid  = cpu_req | dev_req;
        winner = GRANT_CPU;
        if (cpu_req && dev_req) begin
            winner = (last_winner == GRANT_DEV) ? GRANT_CPU : GRANT_DEV;
        end else if (dev_req) begin
            winner = GRANT_DEV;
        end
    end

endmodule

// File: rtl/mio_arbiter.sv
// Two-master arbiter in front of a single fixed-latency memory. One
// transaction at a time runs IDLE -> ACCESS -> WAIT (MEM_LATENCY cycles) ->
// DONE -> IDLE; DONE pulses MIO_ready or dev_ack with the captured read data.
// Build option: define MIO_ARB_ROUND_ROBIN_EN to alternate simultaneous
// requests; otherwise the CPU always wins a tie and no history is kept.
module mio_arbiter
    import mio_arb_pkg::*;
#(
    parameter int MEM_LATENCY = MEM_LATENCY_DEF   // legal range 1..15
) (
    input  logic      clk,
    input  logic      rst,
    mio_arb_if.slave  bus
);

    state_e           state;
    state_e           state_nxt;
    grant_e           grant_r;
    grant_e           last_winner;
    grant_e           pick_winner;
    logic             pick_valid;
    logic             start;
    logic             we_r;
    logic [31:0]      addr_r;
    logic [31:0]      wdata_r;
    logic [31:0]      rdata_r;
    logic [CNT_W-1:0] cnt;

    assign start = (state == S_IDLE) && pick_valid;

    mio_arb_pick u_pick (
        .cpu_req     (bus.cpu_req),
        .dev_req     (bus.dev_req),
        .last_winner (last_winner),
        .winner      (pick_winner),
        .valid       (pick_valid)
    );

`ifdef MIO_ARB_ROUND_ROBIN_EN
    // Remember who won the most recent arbitration; reset favours the CPU first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_winner <= GRANT_DEV;
        end else if (start) begin
            last_winner <= pick_winner;
        end
    end
`else
    // Fixed priority: pretending the device always won last makes the CPU win ties.
    assign last_winner = GRANT_DEV;
`endif

    // NOTE: state uses non-blocking assignments so all flops see pre-edge values; rst is synchronous and only acts on the edge.
    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and decoded outputs.
    always_comb begin
        state_nxt     = state;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.MIO_ready = 1'b0;
        bus.dev_ack   = 1'b0;
        bus.cpu_rdata = '0;
        bus.dev_rdata = '0;

        case (state)
            S_IDLE: begin
                if (pick_valid) state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                bus.mem_en = 1'b1;
                bus.mem_we = we_r;
                state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                if (cnt <= CNT_W'(1)) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (grant_r == GRANT_CPU) begin
                    bus.MIO_ready = 1'b1;
                    bus.cpu_rdata = rdata_r;
                end else begin
                    bus.dev_ack   = 1'b1;
                    bus.dev_rdata = rdata_r;
                end
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Capture the winner's request on start, run the latency counter, grab read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_r <= GRANT_CPU;
            we_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
            rdata_r <= '0;
            cnt     <= '0;
        end else begin
            if (start) begin
                grant_r <= pick_winner;
                if (pick_winner == GRANT_DEV) begin
                    we_r    <= bus.dev_we;
                    addr_r  <= bus.dev_addr;
                    wdata_r <= bus.dev_wdata;
                end else begin
                    we_r    <= bus.cpu_we;
                    addr_r  <= bus.cpu_addr;
                    wdata_r <= bus.cpu_wdata;
                end
            end
            if (state == S_ACCESS) begin
                cnt <= CNT_W'(MEM_LATENCY);
            end
            if (state == S_WAIT) begin
                cnt <= cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) rdata_r <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_addr  = addr_r;
    assign bus.mem_wdata = wdata_r;
    assign bus.grant     = grant_r;
    assign bus.state_out = state;

endmodule
